// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, states, ALU codes and mux encodings
// shared by the multicycle control unit and its opcode decoder.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_RTE  = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_RTE = 6'h13;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_LDA = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [2:0] IORD_PC  = 3'd0;
  localparam logic [2:0] IORD_EXC = 3'd1;
  localparam logic [2:0] IORD_ALU = 3'd2;

  localparam logic [2:0] CAUSE_OPC = 3'd0;
  localparam logic [2:0] CAUSE_OVF = 3'd1;

  localparam logic [2:0] WR_RT = 3'd0;
  localparam logic [2:0] WR_RD = 3'd1;
  localparam logic [2:0] WR_SP = 3'd2;

  localparam logic [4:0] SP_REG      = 5'd29;
  localparam logic [2:0] SP_INIT_SEL = 3'd2;

  localparam logic [3:0] WD_ALU  = 4'd0;
  localparam logic [3:0] WD_LOAD = 4'd1;
  localparam logic [3:0] WD_SP   = {1'b0, SP_INIT_SEL};

  localparam logic [2:0] SRCA_PC = 3'd0;
  localparam logic [2:0] SRCA_A  = 3'd1;

  localparam logic [2:0] SRCB_B    = 3'd0;
  localparam logic [2:0] SRCB_4    = 3'd1;
  localparam logic [2:0] SRCB_IMM  = 3'd2;
  localparam logic [2:0] SRCB_IMM2 = 3'd3;

  localparam logic [2:0] PCS_ALU = 3'd0;
  localparam logic [2:0] PCS_OUT = 3'd1;
  localparam logic [2:0] PCS_JMP = 3'd2;
  localparam logic [2:0] PCS_EPC = 3'd3;
  localparam logic [2:0] PCS_VEC = 3'd4;

  typedef enum logic [4:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EX_R,
    S_WB_R,
    S_EX_I,
    S_WB_I,
    S_ADDR,
    S_MEM_RD,
    S_WB_L,
    S_MEM_WR,
    S_BR,
    S_JMP,
    S_EXC_OPC,
    S_EXC_OVF,
    S_RTE
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       load_ab;
    logic       aluout_load;
    logic       epc_write;
    logic [2:0] alu_op;
    logic [2:0] iord;
    logic [2:0] exc;
    logic [2:0] wr_reg;
    logic [3:0] wd_reg;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] pc_src;
    logic       sing_ex;
  } ctrl_t;

  // add and sub trap on signed overflow; and never does
  function automatic logic fn_traps(logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

endpackage

// File: rtl/cpu_ctrl_unit_decode.sv
// cpu_ctrl_decode: OP/Funct to the state following DECODE.
// Optional RTE_EN adds the return-from-exception encoding.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output state_e     nxt,
  output logic       invalid
);

  // unrecognised encodings fall through to the bad-opcode trap
  always_comb begin
    nxt     = S_EXC_OPC;
    invalid = 1'b1;
    unique case (1'b1)
      (op == OP_R) &&
      (funct inside {FN_ADD, FN_SUB, FN_AND}): begin
        nxt     = S_EX_R;
        invalid = 1'b0;
      end
      (op == OP_ADDI): begin
        nxt     = S_EX_I;
        invalid = 1'b0;
      end
      (op == OP_LW),
      (op == OP_SW): begin
        nxt     = S_ADDR;
        invalid = 1'b0;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        nxt     = S_BR;
        invalid = 1'b0;
      end
      (op == OP_J): begin
        nxt     = S_JMP;
        invalid = 1'b0;
      end
`ifdef RTE_EN
      (op == OP_RTE) && (funct == FN_RTE): begin
        nxt     = S_RTE;
        invalid = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// cpu_ctrl_unit: multicycle main control FSM for the MIPS-subset cpu.
// Define RTE_EN to decode OP=0x10/Funct=0x13 as return-from-exception.
module cpu_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  output logic       PcWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       Load_AB,
  output logic       ALUOut_Load,
  output logic       EPCwrite,
  output logic [2:0] ALUOp,
  output logic [2:0] IorD,
  output logic [2:0] ExCauxe,
  output logic [2:0] WR_REG,
  output logic [3:0] WD_REG,
  output logic [2:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] PcSource,
  output logic       SingExCtrl,
  output logic [1:0] LoadCtrl,
  output logic [1:0] StoreCtrl,
  output logic [4:0] state_dbg
);

  localparam int CW = $clog2(MEM_WAIT + 2);
  localparam logic [CW-1:0] LAST_MEM = CW'(MEM_WAIT - 1);
  localparam logic [CW-1:0] LAST_EXC = CW'(MEM_WAIT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            boot_q, boot_d;
  ctrl_t           out_q, out_d;
  state_e          dec_nxt;
  logic            dec_inv;
  logic            br_take;

  cpu_ctrl_decode u_dec (
    .op      (OP),
    .funct   (Funct),
    .nxt     (dec_nxt),
    .invalid (dec_inv)
  );

  // Moore control word for a state and its in-state cycle count
  function automatic ctrl_t moore(state_e s,
                                 logic [CW-1:0] c,
                                 logic [5:0] fn);
    ctrl_t o;
    o = '0;
    unique case (s)
      S_RST: begin
        o.wr_reg    = WR_SP;
        o.wd_reg    = WD_SP;
        o.reg_write = 1'b1;
      end
      S_FETCH: begin
        o.iord   = IORD_PC;
        o.src_a  = SRCA_PC;
        o.src_b  = SRCB_4;
        o.alu_op = ALU_ADD;
        if (c == LAST_MEM) begin
          o.ir_write = 1'b1;
          o.pc_write = 1'b1;
          o.pc_src   = PCS_ALU;
        end
      end
      S_DECODE: begin
        o.load_ab     = 1'b1;
        o.src_a       = SRCA_PC;
        o.src_b       = SRCB_IMM2;
        o.alu_op      = ALU_ADD;
        o.aluout_load = 1'b1;
      end
      S_EX_R: begin
        o.src_a       = SRCA_A;
        o.src_b       = SRCB_B;
        o.aluout_load = 1'b1;
        o.alu_op      = (fn == FN_SUB) ? ALU_SUB :
                        (fn == FN_AND) ? ALU_AND : ALU_ADD;
      end
      S_WB_R: begin
        o.wr_reg    = WR_RD;
        o.wd_reg    = WD_ALU;
        o.reg_write = 1'b1;
      end
      S_EX_I, S_ADDR: begin
        o.src_a       = SRCA_A;
        o.src_b       = SRCB_IMM;
        o.alu_op      = ALU_ADD;
        o.aluout_load = 1'b1;
      end
      S_WB_I: begin
        o.wr_reg    = WR_RT;
        o.wd_reg    = WD_ALU;
        o.reg_write = 1'b1;
      end
      S_MEM_RD: o.iord = IORD_ALU;
      S_WB_L: begin
        o.wr_reg    = WR_RT;
        o.wd_reg    = WD_LOAD;
        o.reg_write = 1'b1;
      end
      S_MEM_WR: begin
        o.iord      = IORD_ALU;
        o.mem_write = 1'b1;
      end
      S_BR: begin
        o.alu_op = ALU_CMP;
        o.src_a  = SRCA_A;
        o.src_b  = SRCB_B;
        o.pc_src = PCS_OUT;
      end
      S_JMP: begin
        o.pc_src   = PCS_JMP;
        o.pc_write = 1'b1;
      end
      S_RTE: begin
        o.pc_src   = PCS_EPC;
        o.pc_write = 1'b1;
      end
      S_EXC_OPC, S_EXC_OVF: begin
        if (c == '0) begin
          o.src_a     = SRCA_PC;
          o.src_b     = SRCB_4;
          o.alu_op    = ALU_SUB;
          o.epc_write = 1'b1;
        end else begin
          o.iord = IORD_EXC;
          o.exc  = (s == S_EXC_OVF) ? CAUSE_OVF : CAUSE_OPC;
        end
        if (c == LAST_EXC) begin
          o.sing_ex  = 1'b1;
          o.pc_src   = PCS_VEC;
          o.pc_write = 1'b1;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  // next state, in-state cycle count and next control word
  always_comb begin
    state_d = state_q;
    boot_d  = 1'b0;
    unique case (state_q)
      S_RST:
        state_d = boot_q ? S_RST : S_FETCH;
      S_FETCH:
        if (cnt_q == LAST_MEM) state_d = S_DECODE;
      S_DECODE:
        state_d = dec_inv ? S_EXC_OPC : dec_nxt;
      S_EX_R:
        state_d = (ALU_overflow && fn_traps(Funct)) ?
                  S_EXC_OVF : S_WB_R;
      S_EX_I:
        state_d = ALU_overflow ? S_EXC_OVF : S_WB_I;
      S_ADDR:
        state_d = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (cnt_q == LAST_MEM) state_d = S_WB_L;
      S_EXC_OPC, S_EXC_OVF:
        if (cnt_q == LAST_EXC) state_d = S_FETCH;
      default:
        state_d = S_FETCH;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
    out_d = moore(state_d, cnt_d, Funct);
  end

  // state, counter and registered control word; reset clears all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      boot_q  <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      boot_q  <= boot_d;
      out_q   <= out_d;
    end
  end

  // branch PC load follows the live zero flag
  always_comb begin
    br_take = 1'b0;
    if (state_q == S_BR)
      br_take = (OP == OP_BEQ) ? ALU_zero : !ALU_zero;
  end

  assign PcWrite     = out_q.pc_write | br_take;
  assign MemWrite    = out_q.mem_write;
  assign IRWrite     = out_q.ir_write;
  assign RegWrite    = out_q.reg_write;
  assign Load_AB     = out_q.load_ab;
  assign ALUOut_Load = out_q.aluout_load;
  assign EPCwrite    = out_q.epc_write;
  assign ALUOp       = out_q.alu_op;
  assign IorD        = out_q.iord;
  assign ExCauxe     = out_q.exc;
  assign WR_REG      = out_q.wr_reg;
  assign WD_REG      = out_q.wd_reg;
  assign ALUSrcA     = out_q.src_a;
  assign ALUSrcB     = out_q.src_b;
  assign PcSource    = out_q.pc_src;
  assign SingExCtrl  = out_q.sing_ex;
  assign LoadCtrl    = 2'b00;
  assign StoreCtrl   = 2'b00;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// tb_cpu_ctrl_unit: directed instruction sequences with a per-cycle
// scoreboard of expected control words (RTE_EN selects RTE expectations).
module tb_cpu_ctrl_unit;
  import cpu_ctrl_pkg::*;

  localparam int MW = 2;

  localparam logic [6:0] PCW  = 7'b1000000;
  localparam logic [6:0] MEMW = 7'b0100000;
  localparam logic [6:0] IRW  = 7'b0010000;
  localparam logic [6:0] REGW = 7'b0001000;
  localparam logic [6:0] LDAB = 7'b0000100;
  localparam logic [6:0] AOL  = 7'b0000010;
  localparam logic [6:0] EPCW = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OP = '0;
  logic [5:0] Funct = '0;
  logic       ALU_zero = 1'b0;
  logic       ALU_overflow = 1'b0;
  logic       PcWrite, MemWrite, IRWrite, RegWrite;
  logic       Load_AB, ALUOut_Load, EPCwrite, SingExCtrl;
  logic [2:0] ALUOp, IorD, ExCauxe, WR_REG;
  logic [2:0] ALUSrcA, ALUSrcB, PcSource;
  logic [3:0] WD_REG;
  logic [1:0] LoadCtrl, StoreCtrl;
  logic [4:0] state_dbg;

  always #5 clk = ~clk;

  cpu_ctrl_unit #(.MEM_WAIT(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .OP           (OP),
    .Funct        (Funct),
    .ALU_zero     (ALU_zero),
    .ALU_overflow (ALU_overflow),
    .PcWrite      (PcWrite),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .Load_AB      (Load_AB),
    .ALUOut_Load  (ALUOut_Load),
    .EPCwrite     (EPCwrite),
    .ALUOp        (ALUOp),
    .IorD         (IorD),
    .ExCauxe      (ExCauxe),
    .WR_REG       (WR_REG),
    .WD_REG       (WD_REG),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .PcSource     (PcSource),
    .SingExCtrl   (SingExCtrl),
    .LoadCtrl     (LoadCtrl),
    .StoreCtrl    (StoreCtrl),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    string       tag;
    logic [41:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [41:0] ev(
    state_e st, logic [6:0] en, int aluop, int iord, int exc,
    int wr, int wd, int sa, int sb, int pcs, int sx);
    return {5'(st), en, 3'(aluop), 3'(iord), 3'(exc), 3'(wr),
            4'(wd), 3'(sa), 3'(sb), 3'(pcs), 1'(sx), 4'b0000};
  endfunction

  function automatic logic [41:0] obs();
    return {state_dbg, PcWrite, MemWrite, IRWrite, RegWrite,
            Load_AB, ALUOut_Load, EPCwrite, ALUOp, IorD, ExCauxe,
            WR_REG, WD_REG, ALUSrcA, ALUSrcB, PcSource, SingExCtrl,
            LoadCtrl, StoreCtrl};
  endfunction

  task automatic push(string t, logic [41:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t        e;
    logic [41:0] o;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_empty observed=%h expected=none", obs());
      return;
    end
    e = sbq.pop_front();
    o = obs();
    assert (o === e.v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
    end
  endtask

  task automatic drain();
    int n;
    n = sbq.size();
    repeat (n) begin
      @(posedge clk);
      #1;
      pop_chk();
    end
  endtask

  task automatic set_in(logic [5:0] op, logic [5:0] fn,
                        logic z, logic ov);
    OP           = op;
    Funct        = fn;
    ALU_zero     = z;
    ALU_overflow = ov;
  endtask

  task automatic p_fd();
    for (int i = 0; i < MW - 1; i++)
      push("fetch", ev(S_FETCH, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    push("fetch_last", ev(S_FETCH, PCW | IRW, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    push("decode", ev(S_DECODE, LDAB | AOL, 1, 0, 0, 0, 0, 0, 3, 0, 0));
  endtask

  task automatic p_exc(state_e st, int cause);
    push("exc_epc", ev(st, EPCW, 2, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i < MW; i++)
      push("exc_rd", ev(st, 0, 0, 1, cause, 0, 0, 0, 0, 0, 0));
    push("exc_last", ev(st, PCW, 0, 1, cause, 0, 0, 0, 0, 4, 1));
  endtask

  logic [41:0] e_zero, e_rst, e_wbr, e_exi, e_addr;

  initial begin
    e_zero = ev(S_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_rst  = ev(S_RST, REGW, 0, 0, 0, 2, 2, 0, 0, 0, 0);
    e_wbr  = ev(S_WB_R, REGW, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    e_exi  = ev(S_EX_I, AOL, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    e_addr = ev(S_ADDR, AOL, 1, 0, 0, 0, 0, 1, 2, 0, 0);

    repeat (3) push("in_reset", e_zero);
    drain();
    reset = 1'b1;
    push("sp_init", e_rst);
    drain();

    set_in(OP_R, FN_ADD, 1'b0, 1'b0);
    p_fd();
    push("add_ex", ev(S_EX_R, AOL, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    push("add_wb", e_wbr);
    drain();

    set_in(OP_R, FN_AND, 1'b0, 1'b1);
    p_fd();
    push("and_ex", ev(S_EX_R, AOL, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    push("and_wb", e_wbr);
    drain();

    set_in(OP_R, FN_SUB, 1'b0, 1'b1);
    p_fd();
    push("sub_ex", ev(S_EX_R, AOL, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    p_exc(S_EXC_OVF, 1);
    drain();

    set_in(OP_ADDI, 6'h00, 1'b0, 1'b1);
    p_fd();
    push("addi_ovf_ex", e_exi);
    p_exc(S_EXC_OVF, 1);
    drain();

    set_in(OP_ADDI, 6'h05, 1'b0, 1'b0);
    p_fd();
    push("addi_ex", e_exi);
    push("addi_wb", ev(S_WB_I, REGW, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    set_in(OP_BEQ, 6'h00, 1'b1, 1'b0);
    p_fd();
    push("beq_taken", ev(S_BR, PCW, 7, 0, 0, 0, 0, 1, 0, 1, 0));
    drain();

    set_in(OP_BEQ, 6'h00, 1'b0, 1'b0);
    p_fd();
    push("beq_not", ev(S_BR, 0, 7, 0, 0, 0, 0, 1, 0, 1, 0));
    drain();

    set_in(OP_BNE, 6'h00, 1'b0, 1'b0);
    p_fd();
    push("bne_taken", ev(S_BR, PCW, 7, 0, 0, 0, 0, 1, 0, 1, 0));
    drain();

    set_in(OP_BNE, 6'h00, 1'b1, 1'b0);
    p_fd();
    push("bne_not", ev(S_BR, 0, 7, 0, 0, 0, 0, 1, 0, 1, 0));
    drain();

    set_in(OP_J, 6'h3F, 1'b0, 1'b0);
    p_fd();
    push("jump", ev(S_JMP, PCW, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    drain();

    set_in(OP_SW, 6'h00, 1'b0, 1'b1);
    p_fd();
    push("sw_addr", e_addr);
    push("sw_mem", ev(S_MEM_WR, MEMW, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    drain();

    set_in(OP_LW, 6'h00, 1'b0, 1'b0);
    p_fd();
    push("lw_addr", e_addr);
    for (int i = 0; i < MW; i++)
      push("lw_mem", ev(S_MEM_RD, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    push("lw_wb", ev(S_WB_L, REGW, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    drain();

    set_in(6'h3F, 6'h00, 1'b0, 1'b0);
    p_fd();
    p_exc(S_EXC_OPC, 0);
    drain();

    set_in(OP_R, FN_RTE, 1'b0, 1'b0);
    p_fd();
    p_exc(S_EXC_OPC, 0);
    drain();

    set_in(OP_RTE, FN_RTE, 1'b0, 1'b0);
    p_fd();
`ifdef RTE_EN
    push("rte", ev(S_RTE, PCW, 0, 0, 0, 0, 0, 0, 0, 3, 0));
`else
    p_exc(S_EXC_OPC, 0);
`endif
    drain();

    set_in(OP_LW, 6'h00, 1'b0, 1'b0);
    p_fd();
    push("lw_addr2", e_addr);
    push("lw_mem2", ev(S_MEM_RD, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    drain();
    reset = 1'b0;
    #1;
    push("async_abort", e_zero);
    pop_chk();
    repeat (2) push("abort_hold", e_zero);
    drain();
    reset = 1'b1;
    push("sp_init2", e_rst);
    p_fd();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
